// File: rtl/fifo_rd_packer.sv
// Read-side drain of the async FIFO: pops one word every 3 cycles and packs PACK words into one beat.
// Optional macro RD_PACK_TIMEOUT_EN flushes a partial beat after TIMEOUT idle cycles.

module fifo_rd_packer_lane #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      o_q <= '0;
    else if (i_clr) o_q <= '0;
    else if (i_wr)  o_q <= i_d;
  end
endmodule

module fifo_rd_packer #(
  parameter int WIDTH   = 8,
  parameter int PACK    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       rd_clk,
  input  logic                       res,
  input  logic                       empty,
  input  logic [WIDTH-1:0]           rdata,
  output logic                       rd_en,
  input  logic                       flush,
  output logic [WIDTH*PACK-1:0]      out_data,
  output logic [$clog2(PACK+1)-1:0]  out_cnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                word_cnt
);
  localparam int CW = $clog2(PACK+1);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_CAPT, S_SEND} state_t;

  state_t                       r_state;
  logic [CW-1:0]                r_lane;
  logic [PACK-1:0][WIDTH-1:0]   w_buf;
  logic [PACK-1:0]              w_lane_wr;
  logic                         w_clr;
  logic                         w_tmo;
  logic                         w_go_send;

  // Buffer is cleared on handshake so unfilled lanes of the next beat read as zero.
  assign w_clr = (r_state == S_SEND) && out_ready;

  genvar g;
  generate
    for (g = 0; g < PACK; g++) begin : g_lane
      assign w_lane_wr[g] = (r_state == S_CAPT) && (r_lane == CW'(g));
      fifo_rd_packer_lane #(.WIDTH(WIDTH)) u_lane (
        .i_clk (rd_clk),
        .i_rst (res),
        .i_wr  (w_lane_wr[g]),
        .i_clr (w_clr),
        .i_d   (rdata),
        .o_q   (w_buf[g])
      );
    end
  endgenerate

`ifdef RD_PACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] r_idle;
  assign w_tmo = (r_lane != '0) && empty && (int'(r_idle) == TIMEOUT-1);
`else
  assign w_tmo = 1'b0;
`endif

  assign w_go_send = (r_lane == CW'(PACK)) || (flush && (r_lane != '0)) || w_tmo;

  always_ff @(posedge rd_clk or posedge res) begin
    if (res) begin
      r_state   <= S_IDLE;
      r_lane    <= '0;
      rd_en     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      word_cnt  <= '0;
`ifdef RD_PACK_TIMEOUT_EN
      r_idle    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go_send) begin
            r_state   <= S_SEND;
            out_valid <= 1'b1;
            out_data  <= w_buf;
            out_cnt   <= r_lane;
`ifdef RD_PACK_TIMEOUT_EN
            r_idle    <= '0;
`endif
          end else if (!empty) begin
            r_state <= S_POP;
            rd_en   <= 1'b1;
`ifdef RD_PACK_TIMEOUT_EN
            r_idle  <= '0;
`endif
          end
`ifdef RD_PACK_TIMEOUT_EN
          else if (r_lane != '0) begin
            r_idle <= r_idle + 1'b1;
          end
`endif
        end
        S_POP: begin
          rd_en   <= 1'b0;
          r_state <= S_CAPT;
        end
        // rdata is valid this cycle, one edge after the FIFO sampled rd_en.
        S_CAPT: begin
          r_lane   <= r_lane + 1'b1;
          word_cnt <= word_cnt + 16'd1;
          r_state  <= S_IDLE;
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_lane    <= '0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
